// File: rtl/mem_r_ctrl.sv
// mem_r_ctrl: read-side sequencer for a 4-stage, 16-point FFT.
// Each stage issues 16 natural-order reads from its own bank followed by
// (CNT-16) idle cycles, then advances. A start pulse is handed to the
// downstream write controller LAT-1 cycles into stage 1 so that its first
// write lines up with the first butterfly result.
module mem_r_ctrl #(
  parameter int CNT = 20,  // cycles per stage (16 reads + idle tail)
  parameter int LAT = 3    // RADDR-to-first-result latency, 1..CNT-1
) (
  input  logic       iCLK,
  input  logic       iRSTn,
  input  logic       iStart_R,
  input  logic       iCLR,
  output logic       oEN_RC,
  output logic [6:0] RADDR,
  output logic [1:0] oStage,
  output logic       oStart_W,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    RD1  = 3'b001,
    RD2  = 3'b010,
    RD3  = 3'b011,
    RD4  = 3'b100
  } state_t;

  state_t     state;
  logic [4:0] count;
  logic       lastCnt;

  assign lastCnt = (count == 5'(CNT - 1));

  // Sequencer state and per-stage cycle counter; clear beats start.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
      count <= '0;
    end else if (iCLR) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (iStart_R) state <= RD1;
        end
        RD1: begin
          count <= lastCnt ? 5'd0 : count + 5'd1;
          if (lastCnt) state <= RD2;
        end
        RD2: begin
          count <= lastCnt ? 5'd0 : count + 5'd1;
          if (lastCnt) state <= RD3;
        end
        RD3: begin
          count <= lastCnt ? 5'd0 : count + 5'd1;
          if (lastCnt) state <= RD4;
        end
        RD4: begin
          count <= lastCnt ? 5'd0 : count + 5'd1;
          if (lastCnt) state <= IDLE;
        end
        default: begin
          // Unused encodings recover to idle.
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  logic       active;
  logic [1:0] stageIdx;

  // Decode the active stage index straight from the state register.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    active   = 1'b0;
    stageIdx = 2'd0;
    case (state)
      RD1: begin active = 1'b1; stageIdx = 2'd0; end
      RD2: begin active = 1'b1; stageIdx = 2'd1; end
      RD3: begin active = 1'b1; stageIdx = 2'd2; end
      RD4: begin active = 1'b1; stageIdx = 2'd3; end
      default: begin active = 1'b0; stageIdx = 2'd0; end
    endcase
  end

  // Outputs follow state and counter with no added pipeline delay.
  always_comb begin
    oBusy    = active;
    oStage   = stageIdx;
    oEN_RC   = active && (count < 5'd16);
    RADDR    = active ? {1'b0, stageIdx, count[3:0]} : 7'd0;
    oStart_W = (state == RD1) && (count == 5'(LAT - 1));
    oDone    = (state == RD4) && lastCnt;
  end

endmodule
